// File: rtl/enoc_switch_allocator_pkg.sv
// Shared constants for the ENoC switch allocator: port numbering, allocator states
// and a helper that keeps index widths at least one bit wide.
package enoc_switch_allocator_pkg;

    localparam int unsigned PORT_LOCAL  = 0;
    localparam int unsigned PORT_NORTH  = 1;
    localparam int unsigned PORT_EAST   = 2;
    localparam int unsigned PORT_SOUTH  = 3;
    localparam int unsigned PORT_WEST   = 4;
    localparam int unsigned PORT_TOP    = 5;
    localparam int unsigned PORT_BOTTOM = 6;
    localparam int unsigned DEGREE      = 7;

    localparam logic StIdle   = 1'b0;
    localparam logic StLocked = 1'b1;

    // A single-entry index still needs one wire.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/enoc_switch_allocator_if.sv
// Request/grant bundle between the input queues, the allocator and the crossbar.
// master drives requests and enables; slave is the allocator itself.
interface enoc_switch_allocator_if #(
    parameter int unsigned N = 7,
    parameter int unsigned M = 7
);
    import enoc_switch_allocator_pkg::*;

    localparam int unsigned N_LOG2 = idx_width(N);
    localparam int unsigned M_LOG2 = idx_width(M);

    logic [N-1:0]             i_req_val;
    logic [N-1:0][M_LOG2-1:0] i_req_port;
    logic [M-1:0]             i_en;
    logic [M-1:0][N_LOG2-1:0] o_sel;
    logic [M-1:0]             o_sel_val;
    logic [N-1:0]             o_grant;
    logic                     o_bad_port;

    modport master (
        output i_req_val, i_req_port, i_en,
        input  o_sel, o_sel_val, o_grant, o_bad_port
    );

    modport slave (
        input  i_req_val, i_req_port, i_en,
        output o_sel, o_sel_val, o_grant, o_bad_port
    );

endinterface

// File: rtl/enoc_switch_allocator_rr_arbiter.sv
// Combinational round-robin pick: first unmasked request at or after ptr, searching
// upward modulo N.
module enoc_switch_allocator_rr_arbiter
    import enoc_switch_allocator_pkg::*;
#(
    parameter int unsigned N = 7,
    localparam int unsigned N_LOG2 = idx_width(N)
) (
    input  logic [N-1:0]      req,
    input  logic [N_LOG2-1:0] ptr,
    input  logic [N-1:0]      mask,
    output logic              gnt_val,
    output logic [N_LOG2-1:0] gnt_idx
);

    logic [N-1:0]      req_eff;
    logic [N_LOG2:0]   sum;
    logic [N_LOG2-1:0] idx;

    assign req_eff = req & ~mask;

    always_comb begin
        gnt_val = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        idx     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            // ptr < N and i < N, so one conditional subtract is a full modulo.
            sum = {1'b0, ptr} + (N_LOG2 + 1)'(i);
            if (sum >= (N_LOG2 + 1)'(N)) sum = sum - (N_LOG2 + 1)'(N);
            idx = sum[N_LOG2-1:0];
            if (!gnt_val && req_eff[idx]) begin
                gnt_val = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/enoc_switch_allocator.sv
// Output-port allocator: one locking round-robin arbiter per output, crossbar selects,
// per-input pop strobes and a sticky flag for out-of-range port requests.
module enoc_switch_allocator
    import enoc_switch_allocator_pkg::*;
#(
    parameter int unsigned N = 7,
    parameter int unsigned M = 7
) (
    input logic                     clk,
    input logic                     reset,
    enoc_switch_allocator_if.slave  bus
);

    localparam int unsigned N_LOG2 = idx_width(N);
    localparam int unsigned M_LOG2 = idx_width(M);

    logic [M-1:0][N-1:0]      req;
    logic [M-1:0][N-1:0]      win_mask;
    logic [M-1:0]             state_q, state_d;
    logic [M-1:0][N_LOG2-1:0] ptr_q, ptr_d, sel_q, sel_d, ptr_next;
    logic [M-1:0]             xfer, fresh_val, again_val;
    logic [M-1:0][N_LOG2-1:0] fresh_idx, again_idx;
    logic [N-1:0]             grant;
    logic                     bad_req, bad_q;

    always_comb begin
        req     = '0;
        bad_req = 1'b0;
        for (int unsigned n = 0; n < N; n++) begin
            for (int unsigned m = 0; m < M; m++) begin
                req[m][n] = bus.i_req_val[n] && (bus.i_req_port[n] == M_LOG2'(m));
            end
            if (bus.i_req_val[n] && (32'(bus.i_req_port[n]) >= M)) bad_req = 1'b1;
        end
    end

    always_comb begin
        ptr_next = '0;
        win_mask = '0;
        for (int unsigned m = 0; m < M; m++) begin
            ptr_next[m] = (32'(sel_q[m]) == N - 1) ? '0 : sel_q[m] + 1'b1;
            for (int unsigned n = 0; n < N; n++) begin
                win_mask[m][n] = (32'(sel_q[m]) == n);
            end
        end
    end

    // Fresh pick from IDLE, and back-to-back pick after a transfer with the winner masked.
    for (genvar m = 0; m < M; m++) begin : g_out
        enoc_switch_allocator_rr_arbiter #(.N(N)) u_fresh (
            .req     (req[m]),
            .ptr     (ptr_q[m]),
            .mask    ('0),
            .gnt_val (fresh_val[m]),
            .gnt_idx (fresh_idx[m])
        );

        enoc_switch_allocator_rr_arbiter #(.N(N)) u_again (
            .req     (req[m]),
            .ptr     (ptr_next[m]),
            .mask    (win_mask[m]),
            .gnt_val (again_val[m]),
            .gnt_idx (again_idx[m])
        );

        a_lock_stable: assert property (@(posedge clk) disable iff (reset)
            (state_q[m] == StLocked) |->
                (bus.i_req_val[sel_q[m]] && (bus.i_req_port[sel_q[m]] == M_LOG2'(m))));
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        xfer    = '0;
        for (int unsigned m = 0; m < M; m++) begin
            xfer[m] = (state_q[m] == StLocked) && bus.i_en[m];
            if (state_q[m] == StIdle) begin
                if (fresh_val[m]) begin
                    state_d[m] = StLocked;
                    sel_d[m]   = fresh_idx[m];
                end
            end else if (bus.i_en[m]) begin
                ptr_d[m] = ptr_next[m];
                if (again_val[m]) sel_d[m] = again_idx[m];
                else              state_d[m] = StIdle;
            end
        end
    end

    // Gated by reset so an abandoned lock never pops its queue.
    always_comb begin
        grant = '0;
        for (int unsigned m = 0; m < M; m++) begin
            for (int unsigned n = 0; n < N; n++) begin
                if (xfer[m] && (32'(sel_q[m]) == n) && !reset) grant[n] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= '0;
            ptr_q   <= '0;
            sel_q   <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            bad_q   <= bad_q | bad_req;
        end
    end

    // StLocked is encoded as 1, so the state bits are the select-valid flags.
    assign bus.o_sel      = sel_q;
    assign bus.o_sel_val  = state_q;
    assign bus.o_grant    = grant;
    assign bus.o_bad_port = bad_q;

endmodule

// File: tb/tb_enoc_switch_allocator.sv
// Directed and randomized bench for enoc_switch_allocator against a per-output
// round-robin reference model (N=7 inputs, M=5 outputs so port 6 is out of range).
module tb_enoc_switch_allocator;
    import enoc_switch_allocator_pkg::*;

    localparam int unsigned N = 7;
    localparam int unsigned M = 5;
    localparam int unsigned N_LOG2 = 3;
    localparam int unsigned M_LOG2 = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    enoc_switch_allocator_if #(.N(N), .M(M)) bus ();
    enoc_switch_allocator #(.N(N), .M(M)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    bit           m_lock[M];
    int           m_sel[M];
    int           m_ptr[M];
    bit           m_bad;
    logic [N-1:0] exp_gnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input int ptr, input logic [N-1:0] c);
        int best = -1;
        int bd = N;
        int d;
        for (int n = 0; n < N; n++) begin
            d = (n - ptr + N) % N;
            if (c[n] && d < bd) begin
                bd = d;
                best = n;
            end
        end
        return best;
    endfunction

    task automatic reset_model();
        for (int m = 0; m < M; m++) begin
            m_lock[m] = 0;
            m_sel[m]  = 0;
            m_ptr[m]  = 0;
        end
        m_bad = 0;
    endtask

    task automatic check_model(input string tag);
        logic [M-1:0] ev;
        ev = '0;
        exp_gnt = '0;
        for (int m = 0; m < M; m++) begin
            ev[m] = m_lock[m];
            if (m_lock[m] && bus.i_en[m] && !reset) exp_gnt[m_sel[m]] = 1'b1;
        end
        chk({tag, " sel_val"}, 32'(bus.o_sel_val), 32'(ev));
        chk({tag, " grant"}, 32'(bus.o_grant), 32'(exp_gnt));
        chk({tag, " bad_port"}, 32'(bus.o_bad_port), 32'(m_bad));
        for (int m = 0; m < M; m++) begin
            if (m_lock[m]) chk({tag, " sel"}, 32'(bus.o_sel[m]), m_sel[m]);
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] c;
        if (reset) begin
            reset_model();
            return;
        end
        for (int m = 0; m < M; m++) begin
            for (int n = 0; n < N; n++) c[n] = bus.i_req_val[n] && (int'(bus.i_req_port[n]) == m);
            if (!m_lock[m]) begin
                if (c != '0) begin
                    m_sel[m]  = pick(m_ptr[m], c);
                    m_lock[m] = 1;
                end
            end else if (bus.i_en[m]) begin
                m_ptr[m] = (m_sel[m] + 1) % N;
                c[m_sel[m]] = 1'b0;
                if (c != '0) m_sel[m] = pick(m_ptr[m], c);
                else         m_lock[m] = 0;
            end
        end
        for (int n = 0; n < N; n++) begin
            if (bus.i_req_val[n] && int'(bus.i_req_port[n]) >= M) m_bad = 1;
        end
    endtask

    task automatic settle(input string tag);
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic advance();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_req_val  = '0;
        bus.i_req_port = '0;
        bus.i_en       = '0;
    endtask

    task automatic set_req(input int n, input int p);
        bus.i_req_val[n]  = 1'b1;
        bus.i_req_port[n] = M_LOG2'(p);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        settle("rst_mid");
        chk("rst_mid no grant", 32'(bus.o_grant), 0);
        advance();
        clear_inputs();
        settle("rst_hold");
        chk("rst_hold sel_val", 32'(bus.o_sel_val), 0);
        chk("rst_hold bad", 32'(bus.o_bad_port), 0);
        advance();
        reset = 1'b0;
    endtask

    bit           pending[N];
    int           pport[N];
    int unsigned  r;
    int           seq[6] = '{1, 3, 4, 1, 3, 4};

    initial begin
        reset = 1'b1;
        clear_inputs();
        for (int n = 0; n < N; n++) set_req(n, n % M);
        bus.i_en = '1;
        reset_model();
        @(posedge clk);
        #1;

        // Reset held with every input requesting.
        for (int k = 0; k < 3; k++) begin
            settle("reset");
            chk("reset sel", 32'(bus.o_sel), 0);
            chk("reset grant", 32'(bus.o_grant), 0);
            advance();
        end
        reset = 1'b0;
        settle("first_arb");
        chk("first_arb sel_val", 32'(bus.o_sel_val), 0);
        advance();
        settle("first_lock");
        chk("first_lock sel_val", 32'(bus.o_sel_val), 32'h1f);
        advance();
        do_reset();

        // Single flow 0 -> 2.
        set_req(0, 2);
        bus.i_en[2] = 1'b1;
        settle("single_req");
        chk("single_req sel_val", 32'(bus.o_sel_val), 0);
        advance();
        settle("single_gnt");
        chk("single sel2", 32'(bus.o_sel[2]), 0);
        chk("single sel_val", 32'(bus.o_sel_val), 32'h04);
        chk("single grant", 32'(bus.o_grant), 32'h01);
        advance();
        bus.i_req_val = '0;
        settle("single_done");
        chk("single_done sel_val", 32'(bus.o_sel_val), 0);
        advance();
        do_reset();

        // Contention: inputs 1,3,4 on port 0.
        set_req(1, 0);
        set_req(3, 0);
        set_req(4, 0);
        bus.i_en[0] = 1'b1;
        settle("cont_req");
        advance();
        for (int k = 0; k < 6; k++) begin
            settle("cont");
            chk("cont grant", 32'(bus.o_grant), 32'(1) << seq[k]);
            chk("cont sel_val0", 32'(bus.o_sel_val[0]), 1);
            advance();
        end
        do_reset();

        // Backpressure on port 1.
        set_req(2, 1);
        settle("bp_req");
        advance();
        for (int k = 0; k < 5; k++) begin
            settle("bp_hold");
            chk("bp sel1", 32'(bus.o_sel[1]), 2);
            chk("bp grant", 32'(bus.o_grant), 0);
            advance();
        end
        bus.i_en[1] = 1'b1;
        settle("bp_release");
        chk("bp_release grant", 32'(bus.o_grant), 32'h04);
        advance();
        bus.i_req_val = '0;
        settle("bp_after");
        chk("bp_after grant", 32'(bus.o_grant), 0);
        advance();
        do_reset();

        // Parallel independent flows.
        set_req(0, 1);
        set_req(1, 2);
        set_req(2, 3);
        bus.i_en = '1;
        settle("par_req");
        advance();
        settle("par_gnt");
        chk("par grant", 32'(bus.o_grant), 32'h07);
        advance();
        for (int k = 0; k < 4; k++) begin
            settle("par_run");
            advance();
        end
        do_reset();

        // Out-of-range port.
        set_req(3, 6);
        bus.i_en = '1;
        settle("bad_req");
        chk("bad before edge", 32'(bus.o_bad_port), 0);
        advance();
        settle("bad_set");
        chk("bad set", 32'(bus.o_bad_port), 1);
        chk("bad no grant", 32'(bus.o_grant), 0);
        advance();
        bus.i_req_val = '0;
        for (int k = 0; k < 3; k++) begin
            settle("bad_sticky");
            chk("bad sticky", 32'(bus.o_bad_port), 1);
            advance();
        end
        do_reset();
        settle("bad_cleared");
        chk("bad cleared", 32'(bus.o_bad_port), 0);
        advance();

        // Randomized traffic; requests stay up until granted.
        for (int n = 0; n < N; n++) pending[n] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int n = 0; n < N; n++) begin
                if (pending[n]) begin
                    set_req(n, pport[n]);
                end else begin
                    r = $urandom_range(0, 9);
                    if (r < 5) begin
                        pending[n] = 1;
                        pport[n] = $urandom_range(0, M - 1);
                        set_req(n, pport[n]);
                    end else if (r == 5) begin
                        set_req(n, $urandom_range(M, 7));
                    end else begin
                        bus.i_req_val[n] = 1'b0;
                    end
                end
            end
            for (int m = 0; m < M; m++) bus.i_en[m] = ($urandom_range(0, 3) != 0);
            settle("rand");
            for (int n = 0; n < N; n++) if (exp_gnt[n]) pending[n] = 0;
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
